// File: rtl/serial_fft_sched_if.sv
// Stream interface for serial_fft_sched.
//   s_*  : input sample stream (s_valid/s_ready/s_data)
//   m_*  : per-bin result stream (m_valid/m_ready/m_re/m_im/m_bin/m_last)
// The slave modport is the scheduler side; the master modport is the
// producer of samples and consumer of results.
interface serial_fft_sched_if #(
    parameter int unsigned X_WIDTH = 16,
    parameter int unsigned S_WIDTH = 32,
    parameter int unsigned N_BINS  = 3
);
    localparam int unsigned BIN_W = (N_BINS > 1) ? $clog2(N_BINS) : 1;

    logic               s_valid;
    logic               s_ready;
    logic [X_WIDTH-1:0] s_data;

    logic               m_valid;
    logic               m_ready;
    logic [S_WIDTH-1:0] m_re;
    logic [S_WIDTH-1:0] m_im;
    logic [BIN_W-1:0]   m_bin;
    logic               m_last;

    modport slave (
        input  s_valid, s_data, m_ready,
        output s_ready, m_valid, m_re, m_im, m_bin, m_last
    );

    modport master (
        output s_valid, s_data, m_ready,
        input  s_ready, m_valid, m_re, m_im, m_bin, m_last
    );
endinterface

// File: rtl/serial_fft_sched.sv
// Frame scheduler for the serial FFT core. Buffers one frame of FRAME_LENGTH
// samples, then for each of N_BINS bins: loads the bin's twiddles from an
// external ROM, replays the frame into the core, and waits for the core's
// result, which is presented on the m_* stream.
// Ports:
//   clk, arstn          clock, synchronous active-low reset
//   io (slave)          s_* sample stream in, m_* result stream out
//   coef_addr/coef_rd   ROM request (data back one cycle later)
//   coef_re/coef_im     ROM data
//   core_arstn          core clear, active-low
//   core_w_re/core_w_im twiddle registers driven to the core
//   core_valid_i/core_x sample strobe and sample to the core
//   core_re/core_im     core result, qualified by core_valid_o
//   err                 sticky core-timeout flag
module serial_fft_sched #(
    parameter int unsigned X_WIDTH      = 16,
    parameter int unsigned W_WIDTH      = 16,
    parameter int unsigned S_WIDTH      = 32,
    parameter int unsigned FRAME_LENGTH = 3,
    parameter int unsigned N_BINS       = 3,
    parameter int unsigned TIMEOUT      = 64,
    localparam int unsigned ADDR_W =
        (N_BINS * FRAME_LENGTH > 1) ? $clog2(N_BINS * FRAME_LENGTH) : 1
) (
    input  logic                                  clk,
    input  logic                                  arstn,
    serial_fft_sched_if.slave                     io,
    output logic [ADDR_W-1:0]                     coef_addr,
    output logic                                  coef_rd,
    input  logic [W_WIDTH-1:0]                    coef_re,
    input  logic [W_WIDTH-1:0]                    coef_im,
    output logic                                  core_arstn,
    output logic [FRAME_LENGTH-1:0][W_WIDTH-1:0]  core_w_re,
    output logic [FRAME_LENGTH-1:0][W_WIDTH-1:0]  core_w_im,
    output logic                                  core_valid_i,
    output logic [X_WIDTH-1:0]                    core_x,
    input  logic [S_WIDTH-1:0]                    core_re,
    input  logic [S_WIDTH-1:0]                    core_im,
    input  logic                                  core_valid_o,
    output logic                                  err
);
    localparam int unsigned BIN_W = (N_BINS > 1) ? $clog2(N_BINS) : 1;
    localparam int unsigned CNT_W = $clog2(FRAME_LENGTH + 1);
    localparam int unsigned TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    // StHold is the LOAD-wait: the previous result must drain before a load.
    typedef enum logic [2:0] {StFill, StHold, StLoad, StRun, StWait} state_e;

    state_e                               state_q;
    logic [CNT_W-1:0]                     cnt_q;
    logic [BIN_W-1:0]                     bin_q;
    logic [TMO_W-1:0]                     tmo_q;
    logic [X_WIDTH-1:0]                   buf_q [FRAME_LENGTH];
    logic                                 s_ready_q;
    logic                                 coef_rd_q;
    logic [ADDR_W-1:0]                    coef_addr_q;
    logic                                 core_arstn_q;
    logic                                 core_valid_q;
    logic [X_WIDTH-1:0]                   core_x_q;
    logic [FRAME_LENGTH-1:0][W_WIDTH-1:0] w_re_q;
    logic [FRAME_LENGTH-1:0][W_WIDTH-1:0] w_im_q;
    logic                                 m_valid_q;
    logic [S_WIDTH-1:0]                   m_re_q;
    logic [S_WIDTH-1:0]                   m_im_q;
    logic [BIN_W-1:0]                     m_bin_q;
    logic                                 m_last_q;
    logic                                 err_q;

    logic s_fire;
    logic start_ok;
    logic last_cnt;
    logic last_bin;

    assign s_fire   = s_ready_q && io.s_valid;
    // Output register will be empty in the next cycle.
    assign start_ok = !m_valid_q || io.m_ready;
    assign last_cnt = (cnt_q == CNT_W'(FRAME_LENGTH - 1));
    assign last_bin = (bin_q == BIN_W'(N_BINS - 1));

    always_ff @(posedge clk) begin
        if (s_fire) begin
            buf_q[cnt_q] <= io.s_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!arstn) begin
            state_q      <= StFill;
            cnt_q        <= '0;
            bin_q        <= '0;
            tmo_q        <= '0;
            s_ready_q    <= 1'b1;
            coef_rd_q    <= 1'b0;
            coef_addr_q  <= '0;
            core_arstn_q <= 1'b0;
            core_valid_q <= 1'b0;
            core_x_q     <= '0;
            w_re_q       <= '0;
            w_im_q       <= '0;
            m_valid_q    <= 1'b0;
            m_re_q       <= '0;
            m_im_q       <= '0;
            m_bin_q      <= '0;
            m_last_q     <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            if (m_valid_q && io.m_ready) begin
                m_valid_q <= 1'b0;
                m_re_q    <= '0;
                m_im_q    <= '0;
                m_bin_q   <= '0;
                m_last_q  <= 1'b0;
            end

            unique case (state_q)
                StFill: begin
                    if (s_fire) begin
                        if (last_cnt) begin
                            s_ready_q <= 1'b0;
                            bin_q     <= '0;
                            cnt_q     <= '0;
                            if (start_ok) begin
                                state_q      <= StLoad;
                                coef_rd_q    <= 1'b1;
                                coef_addr_q  <= '0;
                                core_arstn_q <= 1'b0;
                            end else begin
                                state_q <= StHold;
                            end
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                end
                StHold: begin
                    if (start_ok) begin
                        state_q      <= StLoad;
                        cnt_q        <= '0;
                        coef_rd_q    <= 1'b1;
                        coef_addr_q  <= ADDR_W'(32'(bin_q) * FRAME_LENGTH);
                        core_arstn_q <= 1'b0;
                    end
                end
                StLoad: begin
                    core_arstn_q <= 1'b1;
                    // ROM data for the read issued last cycle lands now.
                    if (cnt_q != '0) begin
                        w_re_q[cnt_q - 1'b1] <= coef_re;
                        w_im_q[cnt_q - 1'b1] <= coef_im;
                    end
                    if (cnt_q < CNT_W'(FRAME_LENGTH - 1)) begin
                        coef_addr_q <= coef_addr_q + 1'b1;
                    end else begin
                        coef_rd_q <= 1'b0;
                    end
                    if (cnt_q == CNT_W'(FRAME_LENGTH)) begin
                        state_q      <= StRun;
                        cnt_q        <= '0;
                        core_valid_q <= 1'b1;
                        core_x_q     <= buf_q[0];
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                StRun: begin
                    if (last_cnt) begin
                        core_valid_q <= 1'b0;
                        state_q      <= StWait;
                        tmo_q        <= '0;
                    end else begin
                        cnt_q    <= cnt_q + 1'b1;
                        core_x_q <= buf_q[cnt_q + 1'b1];
                    end
                end
                StWait: begin
                    if (core_valid_o) begin
                        m_valid_q <= 1'b1;
                        m_re_q    <= core_re;
                        m_im_q    <= core_im;
                        m_bin_q   <= bin_q;
                        m_last_q  <= last_bin;
                        if (last_bin) begin
                            state_q   <= StFill;
                            cnt_q     <= '0;
                            bin_q     <= '0;
                            s_ready_q <= 1'b1;
                        end else begin
                            bin_q   <= bin_q + 1'b1;
                            state_q <= StHold;
                        end
                    end else if (tmo_q == TMO_W'(TIMEOUT - 1)) begin
                        // Core never answered: drop the frame.
                        err_q     <= 1'b1;
                        state_q   <= StFill;
                        cnt_q     <= '0;
                        bin_q     <= '0;
                        s_ready_q <= 1'b1;
                    end else begin
                        tmo_q <= tmo_q + 1'b1;
                    end
                end
                default: state_q <= StFill;
            endcase
        end
    end

    assign io.s_ready   = s_ready_q;
    assign io.m_valid   = m_valid_q;
    assign io.m_re      = m_re_q;
    assign io.m_im      = m_im_q;
    assign io.m_bin     = m_bin_q;
    assign io.m_last    = m_last_q;
    assign coef_rd      = coef_rd_q;
    assign coef_addr    = coef_addr_q;
    assign core_arstn   = core_arstn_q;
    assign core_valid_i = core_valid_q;
    assign core_x       = core_x_q;
    assign core_w_re    = w_re_q;
    assign core_w_im    = w_im_q;
    assign err          = err_q;
endmodule

// File: tb/tb_serial_fft_sched.sv
// Bench for serial_fft_sched: behavioural coefficient ROM and serial core,
// scoreboard of expected bin results computed from the samples and the ROM.
module tb_serial_fft_sched;
    localparam int unsigned XW = 16;
    localparam int unsigned WW = 16;
    localparam int unsigned SW = 32;
    localparam int unsigned FL = 3;
    localparam int unsigned NB = 3;
    localparam int unsigned TMO = 64;
    localparam int unsigned CORE_LAT = 2;

    typedef logic signed [XW-1:0] frame_t [FL];
    typedef struct {
        logic signed [SW-1:0] re;
        logic signed [SW-1:0] im;
        logic [1:0]           bin;
        logic                 last;
    } exp_t;

    logic clk = 1'b0;
    logic arstn = 1'b0;
    always #5 clk = ~clk;

    serial_fft_sched_if #(.X_WIDTH(XW), .S_WIDTH(SW), .N_BINS(NB)) bus ();

    logic [3:0]                coef_addr;
    logic                      coef_rd;
    logic signed [WW-1:0]      coef_re = '0;
    logic signed [WW-1:0]      coef_im = '0;
    logic                      core_arstn;
    logic [FL-1:0][WW-1:0]     core_w_re;
    logic [FL-1:0][WW-1:0]     core_w_im;
    logic                      core_valid_i;
    logic [XW-1:0]             core_x;
    logic signed [SW-1:0]      core_re = '0;
    logic signed [SW-1:0]      core_im = '0;
    logic                      core_valid_o = 1'b0;
    logic                      err;

    serial_fft_sched #(
        .X_WIDTH(XW), .W_WIDTH(WW), .S_WIDTH(SW),
        .FRAME_LENGTH(FL), .N_BINS(NB), .TIMEOUT(TMO)
    ) dut (
        .clk(clk), .arstn(arstn), .io(bus),
        .coef_addr(coef_addr), .coef_rd(coef_rd), .coef_re(coef_re), .coef_im(coef_im),
        .core_arstn(core_arstn), .core_w_re(core_w_re), .core_w_im(core_w_im),
        .core_valid_i(core_valid_i), .core_x(core_x),
        .core_re(core_re), .core_im(core_im), .core_valid_o(core_valid_o),
        .err(err)
    );

    int n_checks = 0;
    int n_fail = 0;
    exp_t sb_q[$];
    logic [3:0] addr_log[$];
    int acc_cnt = 0;

    logic signed [WW-1:0] rom_re [NB*FL];
    logic signed [WW-1:0] rom_im [NB*FL];

    function automatic logic signed [SW-1:0] mul(input logic signed [XW-1:0] a,
                                                 input logic signed [WW-1:0] b);
        logic signed [SW-1:0] ea;
        logic signed [SW-1:0] eb;
        ea = SW'(a);
        eb = SW'(b);
        return ea * eb;
    endfunction

    // ROM: one-cycle read latency.
    always @(posedge clk) begin
        if (coef_rd) begin
            coef_re <= rom_re[coef_addr];
            coef_im <= rom_im[coef_addr];
        end
    end

    // Core: accumulates x*w over one frame, answers CORE_LAT cycles later.
    logic core_mute = 1'b0;
    logic signed [SW-1:0] acc_re = '0;
    logic signed [SW-1:0] acc_im = '0;
    int smp = 0;
    int dly = 0;
    logic pend = 1'b0;
    always @(posedge clk) begin
        core_valid_o <= 1'b0;
        if (!core_arstn) begin
            acc_re <= '0;
            acc_im <= '0;
            smp <= 0;
            pend <= 1'b0;
        end else if (core_valid_i) begin
            acc_re <= acc_re + mul(core_x, core_w_re[smp]);
            acc_im <= acc_im + mul(core_x, core_w_im[smp]);
            if (smp == FL - 1) begin
                smp <= 0;
                pend <= 1'b1;
                dly <= CORE_LAT;
            end else begin
                smp <= smp + 1;
            end
        end else if (pend) begin
            if (dly == 0) begin
                pend <= 1'b0;
                if (!core_mute) begin
                    core_valid_o <= 1'b1;
                    core_re <= acc_re;
                    core_im <= acc_im;
                end
            end else begin
                dly <= dly - 1;
            end
        end
    end

    // Scoreboard monitor.
    always @(negedge clk) begin
        if (arstn) begin
            if (bus.m_valid && bus.m_ready) begin
                n_checks++;
                if (sb_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL result: got unexpected bin %0d re %0d, required no result",
                             bus.m_bin, $signed(bus.m_re));
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    if (bus.m_re !== e.re || bus.m_im !== e.im || bus.m_bin !== e.bin ||
                        bus.m_last !== e.last) begin
                        n_fail++;
                        $display("FAIL result: got re=%0d im=%0d bin=%0d last=%0d, required re=%0d im=%0d bin=%0d last=%0d",
                                 $signed(bus.m_re), $signed(bus.m_im), bus.m_bin, bus.m_last,
                                 e.re, e.im, e.bin, e.last);
                    end
                end
            end
            if (coef_rd) addr_log.push_back(coef_addr);
            if (bus.s_valid && bus.s_ready) acc_cnt++;
        end
    end

    task automatic push_frame(input frame_t x);
        exp_t e;
        for (int b = 0; b < NB; b++) begin
            e.re = '0;
            e.im = '0;
            for (int n = 0; n < FL; n++) begin
                e.re = e.re + mul(x[n], rom_re[b*FL+n]);
                e.im = e.im + mul(x[n], rom_im[b*FL+n]);
            end
            e.bin = 2'(b);
            e.last = (b == NB - 1);
            sb_q.push_back(e);
        end
    endtask

    task automatic send_sample(input logic signed [XW-1:0] x, output bit ok);
        int c = 0;
        bus.s_valid = 1'b1;
        bus.s_data = x;
        @(negedge clk);
        while (!bus.s_ready && c < 300) begin
            @(negedge clk);
            c++;
        end
        ok = bus.s_ready;
        @(posedge clk);
        #1;
        bus.s_valid = 1'b0;
    endtask

    task automatic send_frame(input frame_t x, output bit ok);
        bit k;
        ok = 1'b1;
        for (int n = 0; n < FL; n++) begin
            send_sample(x[n], k);
            ok = ok & k;
        end
    endtask

    task automatic wait_drain(output bit ok);
        int c = 0;
        while (sb_q.size() != 0 && c < 500) begin
            @(negedge clk);
            c++;
        end
        ok = (sb_q.size() == 0);
        sb_q.delete();
        @(posedge clk);
        #1;
    endtask

    task automatic rom_unit();
        for (int i = 0; i < NB*FL; i++) begin
            rom_re[i] = 16'sd1;
            rom_im[i] = 16'sd0;
        end
    endtask

    task automatic test_reset();
        bus.s_valid = 1'b0;
        bus.s_data = '0;
        bus.m_ready = 1'b1;
        arstn = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        arstn = 1'b1;
        @(negedge clk);
        n_checks++;
        if (bus.s_ready !== 1'b1) begin n_fail++; $display("FAIL reset_s_ready: got %b, required 1", bus.s_ready); end
        n_checks++;
        if (bus.m_valid !== 1'b0) begin n_fail++; $display("FAIL reset_m_valid: got %b, required 0", bus.m_valid); end
        n_checks++;
        if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b, required 0", err); end
        n_checks++;
        if (core_valid_i !== 1'b0 || coef_rd !== 1'b0) begin
            n_fail++; $display("FAIL reset_strobes: got core_valid_i=%b coef_rd=%b, required 0 0", core_valid_i, coef_rd);
        end
        n_checks++;
        if (core_arstn !== 1'b0) begin n_fail++; $display("FAIL reset_core_arstn: got %b, required 0", core_arstn); end
        n_checks++;
        if (core_w_re !== '0 || core_w_im !== '0) begin
            n_fail++; $display("FAIL reset_twiddles: got %h %h, required 0", core_w_re, core_w_im);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_basic();
        frame_t x;
        bit ok;
        rom_unit();
        x = '{16'sd1, 16'sd2, 16'sd3};
        push_frame(x);
        send_frame(x, ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL basic_send: got s_ready stuck low, required accept"); end
        wait_drain(ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL basic_drain: got missing results, required 3 results"); end
    endtask

    task automatic test_bin1();
        frame_t x;
        bit ok;
        rom_unit();
        rom_re[3] = 16'sd1;  rom_im[3] = 16'sd0;
        rom_re[4] = 16'sd0;  rom_im[4] = -16'sd1;
        rom_re[5] = -16'sd1; rom_im[5] = 16'sd0;
        x = '{16'sd1, 16'sd0, 16'sd0};
        addr_log.delete();
        push_frame(x);
        send_frame(x, ok);
        wait_drain(ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL bin1_drain: got missing results, required 3 results"); end
        n_checks++;
        if (addr_log.size() != NB*FL) begin
            n_fail++; $display("FAIL bin1_addr_count: got %0d reads, required %0d", addr_log.size(), NB*FL);
        end else begin
            for (int i = 0; i < NB*FL; i++) begin
                n_checks++;
                if (addr_log[i] !== 4'(i)) begin
                    n_fail++; $display("FAIL bin1_addr: got %0d at read %0d, required %0d", addr_log[i], i, i);
                end
            end
        end
    endtask

    task automatic test_random();
        frame_t x;
        bit ok;
        for (int f = 0; f < 3; f++) begin
            for (int i = 0; i < NB*FL; i++) begin
                rom_re[i] = WW'($urandom_range(0, 65535));
                rom_im[i] = WW'($urandom_range(0, 65535));
            end
            for (int n = 0; n < FL; n++) x[n] = XW'($urandom_range(0, 65535));
            push_frame(x);
            send_frame(x, ok);
            wait_drain(ok);
            n_checks++;
            if (!ok) begin n_fail++; $display("FAIL random_drain: got missing results in frame %0d, required 3", f); end
        end
    endtask

    task automatic test_backpressure();
        frame_t x;
        bit ok;
        int c = 0;
        int addr_n;
        rom_unit();
        rom_re[1] = 16'sd2; rom_im[2] = -16'sd3;
        x = '{16'sd4, 16'sd5, -16'sd6};
        bus.m_ready = 1'b0;
        push_frame(x);
        send_frame(x, ok);
        while (!bus.m_valid && c < 300) begin
            @(negedge clk);
            c++;
        end
        n_checks++;
        if (bus.m_valid !== 1'b1) begin n_fail++; $display("FAIL bp_first: got m_valid=%b, required 1", bus.m_valid); end
        addr_n = addr_log.size();
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            n_checks++;
            if (bus.m_valid !== 1'b1 || bus.m_re !== sb_q[0].re || bus.m_im !== sb_q[0].im ||
                bus.m_bin !== 2'd0 || bus.m_last !== 1'b0) begin
                n_fail++;
                $display("FAIL bp_hold: got v=%b re=%0d im=%0d bin=%0d, required v=1 re=%0d im=%0d bin=0",
                         bus.m_valid, $signed(bus.m_re), $signed(bus.m_im), bus.m_bin, sb_q[0].re, sb_q[0].im);
            end
        end
        n_checks++;
        if (addr_log.size() != addr_n) begin
            n_fail++; $display("FAIL bp_no_load: got %0d ROM reads while stalled, required 0", addr_log.size() - addr_n);
        end
        @(posedge clk);
        #1;
        bus.m_ready = 1'b1;
        wait_drain(ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL bp_drain: got lost results, required 3"); end
    endtask

    task automatic test_gappy();
        frame_t x;
        bit ok;
        int acc0;
        rom_unit();
        rom_im[7] = 16'sd5;
        x = '{16'sd7, -16'sd3, 16'sd2};
        acc0 = acc_cnt;
        push_frame(x);
        for (int n = 0; n < FL; n++) begin
            @(posedge clk);
            #1;
            send_sample(x[n], ok);
        end
        for (int i = 0; i < 10; i++) begin
            bus.s_valid = i[0];
            bus.s_data = 16'sh7fff;
            @(negedge clk);
            n_checks++;
            if (bus.s_ready !== 1'b0) begin n_fail++; $display("FAIL gappy_s_ready: got %b, required 0", bus.s_ready); end
            @(posedge clk);
            #1;
        end
        bus.s_valid = 1'b0;
        n_checks++;
        if (acc_cnt - acc0 != FL) begin
            n_fail++; $display("FAIL gappy_count: got %0d samples accepted, required %0d", acc_cnt - acc0, FL);
        end
        wait_drain(ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL gappy_drain: got missing results, required 3"); end
        @(negedge clk);
        n_checks++;
        if (bus.s_ready !== 1'b1) begin n_fail++; $display("FAIL gappy_refill: got s_ready=%b, required 1", bus.s_ready); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_back_to_back();
        frame_t x1;
        frame_t x2;
        bit ok1;
        bit ok2;
        bit ok;
        rom_unit();
        rom_re[6] = -16'sd2; rom_im[4] = 16'sd9;
        x1 = '{16'sd10, 16'sd20, 16'sd30};
        x2 = '{-16'sd1, 16'sd100, -16'sd7};
        push_frame(x1);
        send_frame(x1, ok1);
        push_frame(x2);
        send_frame(x2, ok2);
        n_checks++;
        if (!(ok1 && ok2)) begin n_fail++; $display("FAIL b2b_send: got ok=%b%b, required 11", ok1, ok2); end
        wait_drain(ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL b2b_drain: got missing results, required 6"); end
    endtask

    task automatic test_timeout();
        frame_t x;
        bit ok;
        int c = 0;
        int w = 0;
        x = '{16'sd1, 16'sd1, 16'sd1};
        core_mute = 1'b1;
        send_frame(x, ok);
        while (!core_valid_i && c < 100) begin @(negedge clk); c++; end
        while (core_valid_i && c < 100) begin @(negedge clk); c++; end
        while (!err && w < TMO + 20) begin @(negedge clk); w++; end
        n_checks++;
        if (err !== 1'b1) begin n_fail++; $display("FAIL timeout_err: got %b, required 1", err); end
        n_checks++;
        if (w != TMO) begin n_fail++; $display("FAIL timeout_cycles: got %0d, required %0d", w, TMO); end
        n_checks++;
        if (bus.s_ready !== 1'b1 || bus.m_valid !== 1'b0) begin
            n_fail++; $display("FAIL timeout_fill: got s_ready=%b m_valid=%b, required 1 0", bus.s_ready, bus.m_valid);
        end
        repeat (5) @(negedge clk);
        n_checks++;
        if (err !== 1'b1) begin n_fail++; $display("FAIL timeout_sticky: got %b, required 1", err); end
        core_mute = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid_run();
        frame_t x;
        bit ok;
        int c = 0;
        x = '{16'sd1, 16'sd2, 16'sd3};
        send_frame(x, ok);
        while (!core_valid_i && c < 100) begin @(negedge clk); c++; end
        n_checks++;
        if (core_valid_i !== 1'b1) begin n_fail++; $display("FAIL rst_run_reach: got core_valid_i=%b, required 1", core_valid_i); end
        arstn = 1'b0;
        @(posedge clk);
        #1;
        n_checks++;
        if (bus.m_valid !== 1'b0 || core_valid_i !== 1'b0 || bus.s_ready !== 1'b1 || err !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_run: got m_valid=%b core_valid_i=%b s_ready=%b err=%b, required 0 0 1 0",
                     bus.m_valid, core_valid_i, bus.s_ready, err);
        end
        @(posedge clk);
        #1;
        arstn = 1'b1;
        repeat (TMO + 10) @(posedge clk);
        #1;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_bin1();
        test_random();
        test_backpressure();
        test_gappy();
        test_timeout();
        test_reset_mid_run();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got simulation still running, required completion");
        $fatal(1, "watchdog expired");
    end
endmodule
